// File: rtl/k005297_mskld_pkg.sv
// k005297_mskld_pkg
// Shared defaults for the 005297 mask-load scheduler: rotation length,
// decrement tap masks for 2-bit / 4-bit modes, and the phase indices used
// for strobe evaluation and timer clear.
package k005297_mskld_pkg;

    localparam int unsigned ROT_LEN_DEF = 20;

    // Decrement taps: phases {0,5} in 2-bit mode, {0,5,10,15} in 4-bit mode
    localparam logic [ROT_LEN_DEF-1:0] DEC_MASK_2B_DEF = 20'h0_0021;
    localparam logic [ROT_LEN_DEF-1:0] DEC_MASK_4B_DEF = 20'h0_8421;

    localparam int unsigned LD_PH0_DEF = 3;
    localparam int unsigned LD_PH1_DEF = 18;
    localparam int unsigned CLR_PH_DEF = 1;

endpackage

// File: rtl/k005297_mskld_chan.sv
// k005297_mskld_chan
// One mask-load channel: down-counting timer, registered load strobe and
// (with K005297_MSKLD_MISS_EN defined) a sticky missed-clear flag.
// Ports:
//   i_MCLK, i_RST_n   clock, async active-low reset
//   tick              clock enable; all state changes only when high
//   dec_strobe        current phase is a decrement phase
//   ld_eval           current phase is a strobe evaluation phase
//   clr_ph            current phase is the clear phase
//   acc_act_n         access active (low); high forces reload and clears miss
//   acq_msk_ld        forced mask-load request
//   reload            timer reload value
//   timer             timer register readback
//   sr_ld             mask shift-register load strobe
//   miss              sticky missed-clear flag (0 when feature disabled)
module k005297_mskld_chan
    import k005297_mskld_pkg::*;
#(
    parameter int unsigned TW = 4
) (
    input  logic          i_MCLK,
    input  logic          i_RST_n,
    input  logic          tick,
    input  logic          dec_strobe,
    input  logic          ld_eval,
    input  logic          clr_ph,
    input  logic          acc_act_n,
    input  logic          acq_msk_ld,
    input  logic [TW-1:0] reload,
    output logic [TW-1:0] timer,
    output logic          sr_ld,
    output logic          miss
);

    localparam logic [TW-1:0] ONE = TW'(1);

    logic timer_zero;
    assign timer_zero = (timer == '0);

    // Timer and strobe both consume pre-tick values of timer and sr_ld
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            timer <= '1;
            sr_ld <= 1'b0;
        end else if (tick) begin
            if (acc_act_n || (sr_ld && clr_ph))
                timer <= reload;
            else if (dec_strobe)
                timer <= timer_zero ? reload : timer - ONE;

            if (ld_eval)
                sr_ld <= timer_zero | acq_msk_ld;
        end
    end

`ifdef K005297_MSKLD_MISS_EN
    // A wrap while the strobe is still pending means the clear phase was missed
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n)
            miss <= 1'b0;
        else if (tick) begin
            if (acc_act_n)
                miss <= 1'b0;
            else if (timer_zero && dec_strobe && sr_ld)
                miss <= 1'b1;
        end
    end
`else
    assign miss = 1'b0;
`endif

endmodule

// File: rtl/k005297_mskld_sched.sv
// k005297_mskld_sched
// Multi-channel mask-load scheduler for the 005297 bubble-memory controller.
// Phase decodes (decrement, strobe evaluation, clear) are computed once here
// and fanned out to CH k005297_mskld_chan instances.
// Optional feature macro: K005297_MSKLD_MISS_EN (sticky missed-clear flags).
// Ports:
//   i_MCLK           master clock
//   i_RST_n          async active-low reset
//   i_CLK2M_PCEN_n   active-low tick enable
//   i_ROT_n          one-cold rotation phase bus
//   i_4BEN_n         0 = 4-bit mode, 1 = 2-bit mode
//   i_RELOAD         shared timer reload value
//   i_ACC_ACT_n      per-channel access active (low)
//   i_ACQ_MSK_LD     per-channel forced mask-load request
//   o_MSKREG_SR_LD   per-channel mask shift-register load strobe
//   o_TIMER          timers, channel c at [c*TW +: TW]
//   o_MISS           per-channel sticky missed-clear flag
module k005297_mskld_sched
    import k005297_mskld_pkg::*;
#(
    parameter int unsigned          CH          = 2,
    parameter int unsigned          TW          = 4,
    parameter int unsigned          ROT_LEN     = ROT_LEN_DEF,
    parameter logic [ROT_LEN-1:0]   DEC_MASK_2B = ROT_LEN'(DEC_MASK_2B_DEF),
    parameter logic [ROT_LEN-1:0]   DEC_MASK_4B = ROT_LEN'(DEC_MASK_4B_DEF),
    parameter int unsigned          LD_PH0      = LD_PH0_DEF,
    parameter int unsigned          LD_PH1      = LD_PH1_DEF,
    parameter int unsigned          CLR_PH      = CLR_PH_DEF
) (
    input  logic                i_MCLK,
    input  logic                i_RST_n,
    input  logic                i_CLK2M_PCEN_n,
    input  logic [ROT_LEN-1:0]  i_ROT_n,
    input  logic                i_4BEN_n,
    input  logic [TW-1:0]       i_RELOAD,
    input  logic [CH-1:0]       i_ACC_ACT_n,
    input  logic [CH-1:0]       i_ACQ_MSK_LD,
    output logic [CH-1:0]       o_MSKREG_SR_LD,
    output logic [CH*TW-1:0]    o_TIMER,
    output logic [CH-1:0]       o_MISS
);

    generate
        if (CH < 1 || CH > 8) begin : g_bad_ch
            $error("k005297_mskld_sched: CH must be 1..8");
        end
        if (TW < 2 || TW > 8) begin : g_bad_tw
            $error("k005297_mskld_sched: TW must be 2..8");
        end
        if (LD_PH0 >= ROT_LEN || LD_PH1 >= ROT_LEN || CLR_PH >= ROT_LEN) begin : g_bad_ph
            $error("k005297_mskld_sched: phase index out of rotation range");
        end
    endgenerate

    logic [ROT_LEN-1:0] dec_mask;
    logic               tick;
    logic               dec_strobe;
    logic               ld_eval;
    logic               clr_ph;

    // Illegal multi-cold / all-ones rotation falls through these OR rules
    assign tick       = ~i_CLK2M_PCEN_n;
    assign dec_mask   = i_4BEN_n ? DEC_MASK_2B : DEC_MASK_4B;
    assign dec_strobe = |(~i_ROT_n & dec_mask);
    assign ld_eval    = ~i_ROT_n[LD_PH0] | ~i_ROT_n[LD_PH1];
    assign clr_ph     = ~i_ROT_n[CLR_PH];

    genvar c;
    generate
        for (c = 0; c < CH; c++) begin : g_chan
            k005297_mskld_chan #(
                .TW(TW)
            ) u_chan (
                .i_MCLK     (i_MCLK),
                .i_RST_n    (i_RST_n),
                .tick       (tick),
                .dec_strobe (dec_strobe),
                .ld_eval    (ld_eval),
                .clr_ph     (clr_ph),
                .acc_act_n  (i_ACC_ACT_n[c]),
                .acq_msk_ld (i_ACQ_MSK_LD[c]),
                .reload     (i_RELOAD),
                .timer      (o_TIMER[c*TW +: TW]),
                .sr_ld      (o_MSKREG_SR_LD[c]),
                .miss       (o_MISS[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_k005297_mskld_sched.sv
// tb_k005297_mskld_sched
// Self-checking bench for k005297_mskld_sched (CH=2, TW=4, default phases).
// A behavioural model tracks every channel; a negedge process compares the
// DUT against it each cycle, and literal expectations pin known points.
module tb_k005297_mskld_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcen_n;
    logic [19:0] rot_n;
    logic        fourben_n;
    logic [3:0]  reload;
    logic [1:0]  acc_n;
    logic [1:0]  acq;
    logic [1:0]  sr_ld;
    logic [7:0]  timer;
    logic [1:0]  miss;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    int m_tmr  [2] = '{15, 15};
    bit m_ld   [2] = '{1'b0, 1'b0};
    bit m_miss [2] = '{1'b0, 1'b0};

    k005297_mskld_sched #(
        .CH(2),
        .TW(4)
    ) dut (
        .i_MCLK         (clk),
        .i_RST_n        (rst_n),
        .i_CLK2M_PCEN_n (pcen_n),
        .i_ROT_n        (rot_n),
        .i_4BEN_n       (fourben_n),
        .i_RELOAD       (reload),
        .i_ACC_ACT_n    (acc_n),
        .i_ACQ_MSK_LD   (acq),
        .o_MSKREG_SR_LD (sr_ld),
        .o_TIMER        (timer),
        .o_MISS         (miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Decrement phases: 0 and 5 always, plus 10 and 15 in 4-bit mode
    function automatic bit dec_active(input logic [19:0] r, input logic m2b);
        if (!r[0] || !r[5]) return 1'b1;
        if (!m2b && (!r[10] || !r[15])) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_tmr[c]  <= 15;
                m_ld[c]   <= 1'b0;
                m_miss[c] <= 1'b0;
            end
        end else if (!pcen_n) begin
            for (int c = 0; c < 2; c++) begin
                if (acc_n[c] || (m_ld[c] && !rot_n[1]))
                    m_tmr[c] <= int'(reload);
                else if (dec_active(rot_n, fourben_n))
                    m_tmr[c] <= (m_tmr[c] == 0) ? int'(reload) : m_tmr[c] - 1;
                if (!rot_n[3] || !rot_n[18])
                    m_ld[c] <= (m_tmr[c] == 0) || acq[c];
`ifdef K005297_MSKLD_MISS_EN
                if (acc_n[c])
                    m_miss[c] <= 1'b0;
                else if (m_tmr[c] == 0 && dec_active(rot_n, fourben_n) && m_ld[c])
                    m_miss[c] <= 1'b1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < 2; c++) begin
                check($sformatf("timer_ch%0d", c), 32'(timer[c*4 +: 4]), 32'(m_tmr[c]));
                check($sformatf("sr_ld_ch%0d", c), 32'(sr_ld[c]), 32'(m_ld[c]));
                check($sformatf("miss_ch%0d", c), 32'(miss[c]), 32'(m_miss[c]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ph;
        rst_n     = 1'b0;
        pcen_n    = 1'b1;
        rot_n     = '1;
        fourben_n = 1'b1;
        reload    = 4'hF;
        acc_n     = 2'b00;
        acq       = 2'b00;
        repeat (3) step();
        check("reset_timer", 32'(timer), 32'h00FF);
        check("reset_sr_ld", 32'(sr_ld), 32'h0);
        check("reset_miss",  32'(miss),  32'h0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        pcen_n = 1'b0;

        // 2-bit mode count-down; ch0 gets a forced load at phase 18 of tick 78
        for (int t = 0; t < 144; t++) begin
            rot_n = ~(20'd1 << (t % 20));
            acq   = (t == 78) ? 2'b01 : 2'b00;
            step();
            if (t == 78) begin
                check("acq_timer", 32'(timer), 32'h77);
                check("acq_sr_ld", 32'(sr_ld), 32'h1);
            end
            if (t == 81) check("clr_timer", 32'(timer), 32'h6F);
            if (t == 83) check("clr_sr_ld", 32'(sr_ld), 32'h0);
            if (t == 140) check("zero_timer", 32'(timer), 32'h09);
            if (t == 143) begin
                check("zero_sr_ld", 32'(sr_ld), 32'h2);
                check("zero_timer2", 32'(timer), 32'h09);
            end
        end

        // No ticks: nothing may change whatever the other inputs do
        pcen_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rot_n  = ~(20'd1 << $urandom_range(0, 19));
            acc_n  = 2'($urandom);
            acq    = 2'($urandom);
            reload = 4'($urandom);
            step();
        end
        check("hold_timer", 32'(timer), 32'h09);
        check("hold_sr_ld", 32'(sr_ld), 32'h2);

        // Asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1;
        check("areset_timer", 32'(timer), 32'hFF);
        check("areset_sr_ld", 32'(sr_ld), 32'h0);
        check("areset_miss",  32'(miss),  32'h0);
        reload = 4'hF;
        acc_n  = 2'b10;
        acq    = 2'b00;
        step();
        rst_n     = 1'b1;
        pcen_n    = 1'b0;
        fourben_n = 1'b0;

        // 4-bit mode, ch1 held inactive
        for (int t = 0; t < 200; t++) begin
            rot_n = ~(20'd1 << (t % 20));
            step();
        end
        check("inact_timer_ch1", 32'(timer[7:4]), 32'hF);
        check("inact_sr_ld_ch1", 32'(sr_ld[1]), 32'h0);

        // Randomized traffic
        ph    = 0;
        acc_n = 2'b00;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 15) == 0) ph = $urandom_range(0, 19);
            else ph = (ph + 1) % 20;
            rot_n = ~(20'd1 << ph);
            if ($urandom_range(0, 99) == 0) rot_n = 20'($urandom);
            pcen_n = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0)
                reload = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 39) == 0) acc_n[0] = ~acc_n[0];
            if ($urandom_range(0, 39) == 0) acc_n[1] = ~acc_n[1];
            if ($urandom_range(0, 99) == 0) fourben_n = ~fourben_n;
            acq = 2'($urandom_range(0, 3) & {2{$urandom_range(0, 7) == 0}});
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end

`ifndef K005297_MSKLD_MISS_EN
        check("miss_tied_off", 32'(miss), 32'h0);
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/k005297_mskld_sched.md
Name: k005297_mskld_sched

Overview:
Multi-channel, parametrised mask-load scheduler for the 005297 bubble-memory controller datapath. Each channel owns a down-counting mask-load timer advanced on selected rotation phases. Each channel drives a mask shift-register load strobe toward its own mask register. It generalises the single-channel fixed 4-bit timer with these additions:
- channel count, timer width and rotation length are parameters;
- reload value is runtime-programmable;
- decrement phases are selectable per mode;
- each channel has a per-channel debug readback.

Parameters:
- CH, 2: number of independent channels (bubble units), 1..8.
- TW, 4: timer width in bits, 2..8.
- ROT_LEN, 20: length of the one-cold rotation phase bus.
- DEC_MASK_2B, bits {0,5} set: rotation phases that decrement in 2-bit mode (i_4BEN_n=1).
- DEC_MASK_4B, bits {0,5,10,15} set: rotation phases that decrement in 4-bit mode (i_4BEN_n=0).
- LD_PH0, 3; LD_PH1, 18: phases on which the load strobe is re-evaluated.
- CLR_PH, 1: phase on which an asserted load strobe reloads the timer.

Ports:
- i_MCLK  in  1  master clock.
- i_RST_n  in  1  asynchronous active-low reset.
- i_CLK2M_PCEN_n  in  1  active-low clock enable ("tick"). All state changes happen only on ticks.
- i_ROT_n  in  ROT_LEN  one-cold rotation phase; bit k low = phase k.
- i_4BEN_n  in  1  mode select: 0 = 4-bit mode, 1 = 2-bit mode. Shared by all channels.
- i_RELOAD  in  TW  timer reload value. Shared by all channels; sampled whenever a reload occurs.
- i_ACC_ACT_n  in  CH  per-channel access active, active low.
- i_ACQ_MSK_LD  in  CH  per-channel forced mask-load request.
- o_MSKREG_SR_LD  out  CH  per-channel mask shift-register load strobe.
- o_TIMER  out  CH*TW  timer values; channel c occupies bits [c*TW +: TW].
- o_MISS  out  CH  sticky missed-clear flag. Only meaningful with the optional feature.

Behaviour:
- Reset (i_RST_n=0, asynchronous): all timers = all-ones; o_MSKREG_SR_LD = 0; o_MISS = 0. Reset does not depend on i_RELOAD.
- dec_strobe (shared by all channels) = OR over k of (~i_ROT_n[k] & MASK[k]). MASK = DEC_MASK_4B when i_4BEN_n = 0, otherwise DEC_MASK_2B.
- Timer update per channel c, on a tick, in priority order:
  1. Reload: if i_ACC_ACT_n[c] = 1, or (o_MSKREG_SR_LD[c] = 1 and i_ROT_n[CLR_PH] = 0): timer <= i_RELOAD.
  2. Decrement: else if dec_strobe: timer <= (timer == 0) ? i_RELOAD : timer - 1. Unsigned, no borrow output.
  3. Hold: otherwise the timer keeps its value.
- Load strobe per channel c, on a tick:
  - if i_ROT_n[LD_PH0] = 0 or i_ROT_n[LD_PH1] = 0: o_MSKREG_SR_LD[c] <= (timer == 0) | i_ACQ_MSK_LD[c], using the pre-update timer value;
  - otherwise it holds.
  - The strobe is therefore registered with one-tick latency from the evaluation phase.
  - Once set, it stays high until the next LD_PH0/LD_PH1 evaluation.
- No tick (i_CLK2M_PCEN_n = 1): all state holds regardless of any other input.
- Simultaneous events:
  - Reload beats decrement.
  - The CLR_PH reload uses the strobe value from before the tick.
  - Timer and strobe update on the same tick from the same pre-tick values.
- Boundary values:
  - i_RELOAD = 0: the timer sits at 0 and the strobe asserts at every evaluation phase.
  - A multi-cold or all-ones i_ROT_n is not legal. The block must behave deterministically anyway (OR/AND rules above), with no assertion required.
- Elaboration checks: LD_PH0, LD_PH1, CLR_PH < ROT_LEN; mask widths = ROT_LEN.
- o_TIMER is a direct register readback with no extra latency.

Optional Feature:
Macro K005297_MSKLD_MISS_EN.
- Enabled: o_MISS[c] sets on a tick where the timer wraps (timer == 0 and dec_strobe) while o_MSKREG_SR_LD[c] = 1. It is sticky and clears only on a tick with i_ACC_ACT_n[c] = 1, or on reset.
- Disabled: o_MISS is tied to 0 and no flag logic is synthesised.

Decomposition:
- Package k005297_mskld_pkg holds:
  - default tap masks DEC_MASK_2B_DEF and DEC_MASK_4B_DEF;
  - default phase indices LD_PH0_DEF, LD_PH1_DEF and CLR_PH_DEF;
  - ROT_LEN_DEF = 20.
- Sub-module k005297_mskld_chan (one timer, one strobe, one miss flag), instantiated CH times in a generate loop.
- dec_strobe and the load/clear phase decodes are computed once at the top level and fanned out to all channels.

Test Plan:
1. Reset then release, CH=2, 2-bit mode, i_RELOAD=4'hF, both ACC_ACT_n=0, tick every cycle, rotation advancing one phase per tick -> timers reach 0 after 15 decrements (2 per rotation). The strobe asserts 1 tick after the next phase 3 or 18. The timer reloads to 0xF on the following phase 1.
2. Same setup in 4-bit mode -> 4 decrements per rotation; the timer reaches 0 about twice as fast as in scenario 1.
3. Channel 1 ACC_ACT_n=1 throughout, channel 0 active -> o_TIMER ch1 stays 0xF and o_MSKREG_SR_LD[1] stays 0, while ch0 counts independently.
4. i_ACQ_MSK_LD[0]=1 at phase 3 with timer=0x7 -> strobe set 1 tick later. The timer reloads to i_RELOAD at the next phase 1.
5. i_CLK2M_PCEN_n=1 for 10 cycles mid-count -> no timer or strobe change. Async reset asserted between ticks -> all outputs 0 and timers 0xF immediately.
6. With K005297_MSKLD_MISS_EN defined: i_RELOAD=0, strobe held high across a wrap -> o_MISS[0] = 1 and stays 1 until ACC_ACT_n[0] = 1 on a tick. Without the macro, o_MISS stays 0.
